// File: rtl/rv64g_l1_refill_seq_if.sv
// rtl/rv64g_l1_refill_seq_if.sv - refill request, TileLink D/E and bank port bundle
interface rv64g_l1_refill_seq_if #(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 53,
  parameter int SINK_W  = 3
);
  // miss handler request
  logic               start_valid;
  logic               start_ready;
  logic [INDEX_W-1:0] start_index;
  logic [2:0]         start_way;
  logic [TAG_W-1:0]   start_tag;

  // TileLink D channel (Grant / GrantData only)
  logic               d_valid;
  logic               d_ready;
  logic [2:0]         d_opcode;
  logic [1:0]         d_param;
  logic [SINK_W-1:0]  d_sink;
  logic               d_denied;
  logic               d_corrupt;
  logic [63:0]        d_data;

  // TileLink E channel (GrantAck)
  logic               e_valid;
  logic               e_ready;
  logic [SINK_W-1:0]  e_sink;

  // L1 bank write port
  logic               bank_gnt;
  logic               bank_req;
  logic               bank_we;
  logic               bank_tag_we;
  logic [INDEX_W-1:0] bank_index;
  logic [2:0]         bank_word;
  logic [2:0]         bank_way;
  logic [7:0]         bank_be;
  logic [63:0]        bank_wdata;
  logic [TAG_W-1:0]   bank_tag;
  logic [1:0]         bank_state;

  // completion
  logic               done;
  logic               error;

  // sequencer side
  modport master (
    input  start_valid, start_index, start_way, start_tag,
    output start_ready,
    input  d_valid, d_opcode, d_param, d_sink, d_denied, d_corrupt, d_data,
    output d_ready,
    output e_valid, e_sink,
    input  e_ready,
    input  bank_gnt,
    output bank_req, bank_we, bank_tag_we, bank_index, bank_word, bank_way,
    output bank_be, bank_wdata, bank_tag, bank_state,
    output done, error
  );

  // miss handler, interconnect and bank side
  modport slave (
    output start_valid, start_index, start_way, start_tag,
    input  start_ready,
    output d_valid, d_opcode, d_param, d_sink, d_denied, d_corrupt, d_data,
    input  d_ready,
    input  e_valid, e_sink,
    output e_ready,
    output bank_gnt,
    input  bank_req, bank_we, bank_tag_we, bank_index, bank_word, bank_way,
    input  bank_be, bank_wdata, bank_tag, bank_state,
    input  done, error
  );
endinterface

// File: rtl/rv64g_l1_refill_seq.sv
// rtl/rv64g_l1_refill_seq.sv - L1 line refill sequencer: D beats to bank writes, then GrantAck
module rv64g_l1_refill_seq #(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 53,
  parameter int SINK_W  = 3,
  parameter int BEATS   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  rv64g_l1_refill_seq_if.master bus
);

  localparam int CNT_W = $clog2(BEATS);

  localparam logic [2:0] OP_GRANT      = 3'd4;
  localparam logic [2:0] OP_GRANT_DATA = 3'd5;

  localparam logic [1:0] MESI_N = 2'd0;
  localparam logic [1:0] MESI_S = 2'd1;
  localparam logic [1:0] MESI_E = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic               err_q;
  logic               done_q;
  logic               done_d;
  logic [INDEX_W-1:0] index_q;
  logic [2:0]         way_q;
  logic [TAG_W-1:0]   tag_q;
  logic [SINK_W-1:0]  sink_q;

  logic               start_fire;
  logic               beat_fire;
  logic               beat_bad;
  logic               is_final;
  logic [1:0]         cap_state;

  // per-beat decode shared by the FSM outputs and the datapath
  always_comb begin
    beat_bad  = bus.d_denied | bus.d_corrupt;
    is_final  = (bus.d_opcode == OP_GRANT) ||
                ((bus.d_opcode == OP_GRANT_DATA) && (beat_cnt_q == CNT_W'(BEATS - 1)));
    cap_state = MESI_N;
    case (bus.d_param)
      2'd0:    cap_state = MESI_E;
      2'd1:    cap_state = MESI_S;
      default: cap_state = MESI_N;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and handshake / bank-write controls
  always_comb begin
    state_d          = state_q;
    done_d           = 1'b0;
    start_fire       = 1'b0;
    beat_fire        = 1'b0;
    bus.start_ready  = 1'b0;
    bus.d_ready      = 1'b0;
    bus.e_valid      = 1'b0;
    bus.bank_req     = 1'b0;
    bus.bank_we      = 1'b0;
    bus.bank_tag_we  = 1'b0;
    bus.bank_state   = MESI_N;
    case (state_q)
      IDLE: begin
        // the done cycle blocks a new request so done_o is never overlapped
        bus.start_ready = !done_q;
        start_fire      = bus.start_valid && !done_q;
        if (start_fire) begin
          state_d = FILL;
        end
      end
      FILL: begin
        bus.bank_req    = bus.d_valid;
        bus.d_ready     = bus.bank_gnt;
        beat_fire       = bus.d_valid && bus.bank_gnt;
        bus.bank_we     = bus.d_valid && (bus.d_opcode == OP_GRANT_DATA) && !beat_bad;
        // tag is rewritten on every beat; keep it invalid until the line is whole
        bus.bank_tag_we = bus.d_valid;
        if (is_final && !err_q && !beat_bad) begin
          bus.bank_state = cap_state;
        end
        if (beat_fire && is_final) begin
          state_d = ACK;
        end
      end
      ACK: begin
        bus.e_valid = 1'b1;
        if (bus.e_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // request latch, beat counter, error accumulation and sink capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      index_q    <= '0;
      way_q      <= '0;
      tag_q      <= '0;
      sink_q     <= '0;
    end else begin
      done_q <= done_d;
      if (start_fire) begin
        index_q    <= bus.start_index;
        way_q      <= bus.start_way;
        tag_q      <= bus.start_tag;
        beat_cnt_q <= '0;
        err_q      <= 1'b0;
      end else if (beat_fire) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
        err_q      <= err_q | beat_bad;
        if (beat_cnt_q == '0) begin
          sink_q <= bus.d_sink;
        end
      end
    end
  end

  assign bus.bank_index = index_q;
  assign bus.bank_way   = way_q;
  assign bus.bank_word  = beat_cnt_q;
  assign bus.bank_be    = 8'hFF;
  assign bus.bank_wdata = bus.d_data;
  assign bus.bank_tag   = tag_q;
  assign bus.e_sink     = sink_q;
  assign bus.done       = done_q;
  assign bus.error      = done_q & err_q;

endmodule

// File: doc/rv64g_l1_refill_seq.md
Name: rv64g_l1_refill_seq

Overview:
- Line-refill sequencer directly upstream of the per-bank L1 data/tag SRAM.
- Consumes TileLink D-channel Grant/GrantData beats and converts each beat into one bank write: 64-bit word, full byte enables, tag and MESI state.
- Issues the E-channel GrantAck once the line is complete.
- Runs one refill at a time, started by the miss handler with a pre-chosen index, way and tag.

Parameters:
INDEX_W, 5, set-index width
TAG_W, 53, tag width
SINK_W, 3, TileLink d_sink / e_sink width
BEATS, 8, data beats per line (64 B / 8 B); word counter width is 3

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
start_valid_i  in  1  refill request from miss handler
start_ready_o  out  1  sequencer idle, request accepted
start_index_i  in  INDEX_W  target set
start_way_i  in  3  victim way
start_tag_i  in  TAG_W  tag to install
d_valid_i  in  1  D beat valid (only Grant=4 / GrantData=5 routed here)
d_ready_o  out  1  D beat accepted
d_opcode_i  in  3  4=Grant, 5=GrantData
d_param_i  in  2  cap: 0=toT, 1=toB, 2=toN
d_sink_i  in  SINK_W  sink id for GrantAck
d_denied_i  in  1  request denied
d_corrupt_i  in  1  beat data corrupt
d_data_i  in  64  beat data
e_valid_o  out  1  GrantAck valid
e_ready_i  in  1  GrantAck accepted
e_sink_o  out  SINK_W  GrantAck sink
bank_gnt_i  in  1  bank port granted to sequencer this cycle
bank_req_o  out  1  bank access valid
bank_we_o  out  1  data write enable
bank_tag_we_o  out  1  tag/state write enable
bank_index_o  out  INDEX_W  set
bank_word_o  out  3  word within line
bank_way_o  out  3  way
bank_be_o  out  8  byte enables
bank_wdata_o  out  64  write data
bank_tag_o  out  TAG_W  tag
bank_state_o  out  2  MESI state
done_o  out  1  one-cycle pulse, refill finished
error_o  out  1  valid with done_o: denied or corrupt seen

Behaviour:
- Reset (async): FSM to IDLE; beat_cnt=0, err=0. Index, way, tag and sink registers are cleared to 0.
- Output values in reset: start_ready_o=1, d_ready_o=0, e_valid_o=0, bank_req_o=0, done_o=0, error_o=0.
- Reset mid-refill: abandons the refill. No GrantAck and no done_o are issued.

FSM: IDLE -> FILL -> ACK -> IDLE.

- IDLE:
  - start_ready_o=1.
  - On start_valid_i: latch index, way and tag; clear beat_cnt and err; go to FILL next cycle.
- FILL:
  - bank_req_o = d_valid_i; d_ready_o = bank_gnt_i.
  - A beat is accepted when d_valid_i && d_ready_o.
  - The bank write is combinational from the D beat, with zero added latency, so back-to-back beats can be accepted at one per cycle.
  - Bank write fields: index and way from the latched values; word = beat_cnt; be=8'hFF; wdata=d_data_i; tag = latched tag.
  - bank_we_o = (opcode==5) && !d_denied_i && !d_corrupt_i.
  - bank_tag_we_o = 1 on every beat. The bank updates tag/state on any write, so non-final beats must write MESI_N to keep the line invalid until it is complete.
  - bank_state_o on non-final beats: MESI_N.
  - bank_state_o on the final beat: param 0 -> MESI_E, param 1 -> MESI_S, param 2 -> MESI_N; forced to MESI_N if err or denied/corrupt is set on the final beat.
  - Final beat: opcode 4 (single beat), or opcode 5 with beat_cnt==BEATS-1.
  - On beat 0: latch d_sink_i.
  - On every accepted beat: err |= d_denied_i | d_corrupt_i; beat_cnt increments and wraps 7->0.
  - Final beat accepted -> go to ACK.
  - d_valid_i without bank_gnt_i: stall. The beat is not consumed, and the bank outputs may toggle with d_valid_i.
- ACK:
  - e_valid_o=1, e_sink_o = latched sink; e_valid_o is held until e_ready_i.
  - On the handshake: next cycle is IDLE with done_o=1 and error_o=err for exactly that cycle.
  - start_ready_o=0 during the done_o cycle, so a new refill starts no earlier than 2 cycles after the E handshake.
- Denied Grant (opcode 4) still writes tag with MESI_N, and still acks.
- start_valid_i outside IDLE is ignored (not accepted).

Test Plan:
- Start index=5, way=3, tag=0x1ABC; GrantData param=0, 8 back-to-back beats with data 0x100+i, bank_gnt_i=1 -> 8 consecutive bank writes, word 0..7, be=FF. State is N on beats 0-6 and E on beat 7. e_valid_o asserts the next cycle with the sink from beat 0. done_o=1 and error_o=0 the cycle after e_ready_i.
- Same stimulus with bank_gnt_i low on alternate cycles -> d_ready_o follows the grant, no beat is lost, word order stays 0..7, and the total is 8 writes.
- Grant (opcode 4) param=1 -> a single write with we=0, tag_we=1, state=S, then GrantAck.
- GrantData with d_corrupt_i=1 on beat 3 -> beat 3 has we=0, the final state is N, and done_o is accompanied by error_o=1.
- GrantData param=2 (toN) -> final state N, error_o=0.
- Reset asserted after beat 4 -> outputs return to reset values immediately. No e_valid_o is raised and no done_o is produced; a fresh refill after reset starts at word 0.
